// File: rtl/mcu_spi_pkg.sv
// Shared types and width helpers for the MCU SPI source multiplexer.
package mcu_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/mcu_spi_sync.sv
// Two-flop synchronizer that resets to 1, so an idle chip-select reads deasserted.
module mcu_spi_sync (
    input  logic clk32,
    input  logic por_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk32 or negedge por_n) begin
        if (!por_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/mcu_spi_mux.sv
// Arbitrates several MCU SPI masters onto one core SPI slave, switching only
// between transfers and holding chip-select high for a guard window on a switch.
//
//   state    | meaning
//   ST_IDLE  | selected source idle; claims and revert are evaluated here
//   ST_BUSY  | selected source has csn low; selection frozen
//   ST_GUARD | mcu_csn forced high, switch to pending at end of window
module mcu_spi_mux
    import mcu_spi_pkg::*;
#(
    parameter int N_SRC         = 2,
    parameter int DEFAULT_SRC   = 0,
    parameter int CLAIM_CYCLES  = 4,
    parameter int GUARD_CYCLES  = 2,
    parameter int REVERT_CYCLES = 0,
    localparam int SEL_W        = sel_w(N_SRC)
) (
    input  logic             clk32,
    input  logic             por_n,
    input  logic [N_SRC-1:0] src_sclk,
    input  logic [N_SRC-1:0] src_csn,
    input  logic [N_SRC-1:0] src_mosi,
    output logic [N_SRC-1:0] src_miso,
    output logic [N_SRC-1:0] src_intn,
    output logic             mcu_sclk,
    output logic             mcu_csn,
    output logic             mcu_mosi,
    input  logic             mcu_miso,
    input  logic             mcu_intn,
    output logic [SEL_W-1:0] sel,
    output logic             switched
);

    localparam int GE = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
    localparam int CW = cnt_w(CLAIM_CYCLES);
    localparam int GW = cnt_w(GE);
    localparam int RW = cnt_w(REVERT_CYCLES);
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SRC);
    localparam logic [CW-1:0]    CLAIM_TC = CW'(CLAIM_CYCLES);

    logic [N_SRC-1:0] csn_s;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        mcu_spi_sync u_sync (
            .clk32 (clk32),
            .por_n (por_n),
            .d     (src_csn[g]),
            .q     (csn_s[g])
        );
    end

    logic [CW-1:0] claim_q [N_SRC];
    logic [CW-1:0] claim_d [N_SRC];

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            claim_d[i] = claim_q[i];
            if (csn_s[i]) begin
                claim_d[i] = '0;
            end else if (claim_q[i] != CLAIM_TC) begin
                claim_d[i] = claim_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk32 or negedge por_n) begin
        if (!por_n) begin
            for (int i = 0; i < N_SRC; i++) begin
                claim_q[i] <= '0;
            end
        end else begin
            claim_q <= claim_d;
        end
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic [RW-1:0]    revert_q, revert_d;
    logic             sw_q, sw_d;
    logic             claim_vld;
    logic [SEL_W-1:0] claim_idx;
    logic             csn_sel;

    // Scan downward so the lowest-index saturated claimant is the one kept.
    always_comb begin
        claim_vld = 1'b0;
        claim_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if ((SEL_W'(i) != sel_q) && (claim_q[i] == CLAIM_TC)) begin
                claim_vld = 1'b1;
                claim_idx = SEL_W'(i);
            end
        end
    end

    assign csn_sel = csn_s[sel_q];

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pend_d   = pend_q;
        guard_d  = guard_q;
        revert_d = revert_q;
        sw_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!csn_sel) begin
                    state_d  = ST_BUSY;
                    revert_d = '0;
                end else if (claim_vld) begin
                    pend_d   = claim_idx;
                    state_d  = ST_GUARD;
                    guard_d  = GW'(GE - 1);
                    revert_d = '0;
                end else if ((REVERT_CYCLES > 0) && (sel_q != DEF_SEL)) begin
                    if (revert_q == RW'(REVERT_CYCLES - 1)) begin
                        pend_d   = DEF_SEL;
                        state_d  = ST_GUARD;
                        guard_d  = GW'(GE - 1);
                        revert_d = '0;
                    end else begin
                        revert_d = revert_q + 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (csn_sel) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (guard_q == '0) begin
                    sel_d   = pend_q;
                    sw_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk32 or negedge por_n) begin
        if (!por_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= DEF_SEL;
            pend_q   <= DEF_SEL;
            guard_q  <= '0;
            revert_q <= '0;
            sw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            guard_q  <= guard_d;
            revert_q <= revert_d;
            sw_q     <= sw_d;
        end
    end

    assign mcu_sclk = src_sclk[sel_q];
    assign mcu_mosi = src_mosi[sel_q];
    assign mcu_csn  = (state_q == ST_GUARD) ? 1'b1 : src_csn[sel_q];

    always_comb begin
        src_miso        = '1;
        src_intn        = '1;
        src_miso[sel_q] = mcu_miso;
        src_intn[sel_q] = mcu_intn;
    end

    assign sel      = sel_q;
    assign switched = sw_q;

endmodule

// File: tb/tb_mcu_spi_mux.sv
// Scoreboard bench for mcu_spi_mux: default, 4-source and reverting instances.
module tb_mcu_spi_mux;

    localparam int REVERT_R = 100;
    localparam int GUARD_R  = 2;

    logic clk32 = 1'b0;
    logic por_n = 1'b0;
    always #5 clk32 = ~clk32;

    logic m_miso = 1'b0;
    logic m_intn = 1'b0;

    logic [1:0] sclk2 = '0, csn2 = '1, mosi2 = '0, miso2, intn2;
    logic       mcu_sclk2, mcu_csn2, mcu_mosi2, sw2;
    logic [0:0] sel2;

    logic [3:0] sclk4 = '0, csn4 = '1, mosi4 = '0, miso4, intn4;
    logic       mcu_sclk4, mcu_csn4, mcu_mosi4, sw4;
    logic [1:0] sel4;

    logic [1:0] sclkr = '0, csnr = '1, mosir = '0, misor, intnr;
    logic       mcu_sclkr, mcu_csnr, mcu_mosir, swr;
    logic [0:0] selr;

    mcu_spi_mux dut2 (
        .clk32(clk32), .por_n(por_n),
        .src_sclk(sclk2), .src_csn(csn2), .src_mosi(mosi2),
        .src_miso(miso2), .src_intn(intn2),
        .mcu_sclk(mcu_sclk2), .mcu_csn(mcu_csn2), .mcu_mosi(mcu_mosi2),
        .mcu_miso(m_miso), .mcu_intn(m_intn),
        .sel(sel2), .switched(sw2)
    );

    mcu_spi_mux #(.N_SRC(4)) dut4 (
        .clk32(clk32), .por_n(por_n),
        .src_sclk(sclk4), .src_csn(csn4), .src_mosi(mosi4),
        .src_miso(miso4), .src_intn(intn4),
        .mcu_sclk(mcu_sclk4), .mcu_csn(mcu_csn4), .mcu_mosi(mcu_mosi4),
        .mcu_miso(m_miso), .mcu_intn(m_intn),
        .sel(sel4), .switched(sw4)
    );

    mcu_spi_mux #(.REVERT_CYCLES(REVERT_R)) dutr (
        .clk32(clk32), .por_n(por_n),
        .src_sclk(sclkr), .src_csn(csnr), .src_mosi(mosir),
        .src_miso(misor), .src_intn(intnr),
        .mcu_sclk(mcu_sclkr), .mcu_csn(mcu_csnr), .mcu_mosi(mcu_mosir),
        .mcu_miso(m_miso), .mcu_intn(m_intn),
        .sel(selr), .switched(swr)
    );

    int n_vec = 0;
    int n_err = 0;
    int q2[$];
    int q4[$];
    int qr[$];
    int sw_seen[3] = '{0, 0, 0};
    int cyc_cnt = 0;
    int swr_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Every switched pulse pops the expected new selection for that instance.
    always @(negedge clk32) begin
        cyc_cnt++;
        if (sw2) begin
            sw_seen[0]++;
            if (q2.size() == 0) chk("sw2_unexpected", {31'd0, sw2}, 32'd0);
            else chk("sw2_sel", {31'd0, sel2}, q2.pop_front());
        end
        if (sw4) begin
            sw_seen[1]++;
            if (q4.size() == 0) chk("sw4_unexpected", {31'd0, sw4}, 32'd0);
            else chk("sw4_sel", {30'd0, sel4}, q4.pop_front());
        end
        if (swr) begin
            sw_seen[2]++;
            swr_cyc = cyc_cnt;
            if (qr.size() == 0) chk("swr_unexpected", {31'd0, swr}, 32'd0);
            else chk("swr_sel", {31'd0, selr}, qr.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk32);
        #1;
    endtask

    task automatic wait_sw(input int which, input int base, input int max_cyc, input string tag);
        int k;
        k = 0;
        while ((sw_seen[which] == base) && (k < max_cyc)) begin
            tick(1);
            k++;
        end
        #5;
        chk(tag, sw_seen[which] - base, 1);
    endtask

    task automatic do_reset();
        por_n  = 1'b0;
        csn2   = '1; csn4 = '1; csnr = '1;
        sclk2  = '0; sclk4 = '0; sclkr = '0;
        m_miso = 1'b0;
        m_intn = 1'b0;
        #2;
        chk("rst_sel2", {31'd0, sel2}, 0);
        chk("rst_sel4", {30'd0, sel4}, 0);
        chk("rst_selr", {31'd0, selr}, 0);
        chk("rst_sw2", {31'd0, sw2}, 0);
        chk("rst_miso2", {30'd0, miso2}, 32'h2);
        chk("rst_intn4", {28'd0, intn4}, 32'he);
        tick(2);
        por_n = 1'b1;
        tick(3);
    endtask

    initial begin
        int base;
        int t_first;
        logic b;

        // Claim with exact timing: GUARD occupies the two cycles before the pulse.
        do_reset();
        csn2[1] = 1'b0;
        q2.push_back(1);
        tick(7);
        csn2[0] = 1'b0;
        #1;
        chk("guard_csn_a", {31'd0, mcu_csn2}, 1);
        chk("guard_sw_a", {31'd0, sw2}, 0);
        tick(1);
        #1;
        chk("guard_csn_b", {31'd0, mcu_csn2}, 1);
        chk("guard_sel_b", {31'd0, sel2}, 0);
        tick(1);
        #1;
        chk("sw_latency", {31'd0, sw2}, 1);
        chk("sel_after", {31'd0, sel2}, 1);
        csn2[0] = 1'b1;
        #1;
        chk("sel1_csn", {31'd0, mcu_csn2}, 0);
        chk("sel1_miso", {30'd0, miso2}, 32'h1);
        chk("sel1_intn", {30'd0, intn2}, 32'h1);
        csn2[1] = 1'b1;
        tick(1);
        #1;
        chk("sw_one_cycle", {31'd0, sw2}, 0);
        tick(10);

        // Three synced-low cycles is one short of a claim; four is enough.
        do_reset();
        csn2[1] = 1'b0;
        tick(3);
        csn2[1] = 1'b1;
        tick(20);
        chk("short_claim_sel", {31'd0, sel2}, 0);
        csn2[1] = 1'b0;
        q2.push_back(1);
        base = sw_seen[0];
        tick(4);
        csn2[1] = 1'b1;
        wait_sw(0, base, 20, "exact_claim_sw");
        chk("exact_claim_sel", {31'd0, sel2}, 1);
        tick(10);

        // Source 0 transfers 8 bytes while source 1 keeps claiming.
        do_reset();
        csn2[0] = 1'b0;
        tick(2);
        csn2[1] = 1'b0;
        base = sw_seen[0];
        for (int i = 0; i < 64; i++) begin
            b        = 1'($urandom_range(0, 1));
            mosi2[0] = b;
            m_miso   = ~b;
            tick(1);
            sclk2[0] = 1'b1;
            #1;
            chk("busy_sclk", {31'd0, mcu_sclk2}, 1);
            chk("busy_mosi", {31'd0, mcu_mosi2}, {31'd0, b});
            chk("busy_miso", {30'd0, miso2}, {30'd0, 1'b1, ~b});
            tick(1);
            sclk2[0] = 1'b0;
        end
        chk("busy_no_sw", sw_seen[0] - base, 0);
        chk("busy_sel", {31'd0, sel2}, 0);
        q2.push_back(1);
        csn2[0] = 1'b1;
        wait_sw(0, base, 30, "busy_release_sw");
        chk("busy_release_sel", {31'd0, sel2}, 1);
        csn2[1] = 1'b1;
        m_miso  = 1'b0;

        // Sticky selection without revert.
        base = sw_seen[0];
        tick(1000);
        chk("sticky_sel", {31'd0, sel2}, 1);
        chk("sticky_no_sw", sw_seen[0] - base, 0);

        // Simultaneous claims on four sources: lowest index wins.
        do_reset();
        csn4[2] = 1'b0;
        csn4[3] = 1'b0;
        q4.push_back(2);
        base = sw_seen[1];
        tick(6);
        csn4[2] = 1'b1;
        csn4[3] = 1'b1;
        wait_sw(1, base, 20, "dual_claim_sw");
        chk("dual_claim_sel", {30'd0, sel4}, 2);
        chk("dual_claim_miso", {28'd0, miso4}, 32'hb);
        tick(20);
        chk("dual_claim_hold", {30'd0, sel4}, 2);

        // Revert to the default source after REVERT_R idle cycles.
        do_reset();
        csnr[1] = 1'b0;
        qr.push_back(1);
        base = sw_seen[2];
        tick(6);
        csnr[1] = 1'b1;
        wait_sw(2, base, 20, "revert_claim_sw");
        t_first = swr_cyc;
        qr.push_back(0);
        base = sw_seen[2];
        wait_sw(2, base, 200, "revert_sw");
        chk("revert_gap", swr_cyc - t_first, REVERT_R + GUARD_R);
        chk("revert_sel", {31'd0, selr}, 0);

        // Reset during GUARD discards the pending switch.
        do_reset();
        base = sw_seen[0];
        csn2[1] = 1'b0;
        tick(6);
        csn2[1] = 1'b1;
        tick(2);
        por_n = 1'b0;
        #1;
        chk("grst_sel", {31'd0, sel2}, 0);
        chk("grst_sw", {31'd0, sw2}, 0);
        chk("grst_miso", {30'd0, miso2}, 32'h2);
        chk("grst_intn", {30'd0, intn2}, 32'h2);
        tick(2);
        por_n = 1'b1;
        tick(30);
        chk("grst_sel_after", {31'd0, sel2}, 0);
        chk("grst_no_sw", sw_seen[0] - base, 0);

        chk("q2_drained", q2.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("qr_drained", qr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mcu_spi_mux.md
MCU_SPI_MUX -- requirements
Module: mcu_spi_mux

Interface
REQ-001 SHALL take parameter N_SRC, default 2: number of MCU SPI sources (1..8).
REQ-002 SHALL take parameter DEFAULT_SRC, default 0: source selected after reset and revert target.
REQ-003 SHALL take parameter CLAIM_CYCLES, default 4: consecutive synced csn-low cycles that make a claim.
REQ-004 SHALL take parameter GUARD_CYCLES, default 2: cycles mcu_csn is forced high during a switch.
REQ-005 SHALL take parameter REVERT_CYCLES, default 0: idle cycles before reverting to DEFAULT_SRC; 0 = sticky, never revert.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk32 in 1 (32 MHz system clock), then por_n in 1 (reset, active low).
REQ-007 SHALL have ports src_sclk, src_csn and src_mosi, each in N_SRC, carrying the per-source SPI inputs.
REQ-008 SHALL have ports src_miso and src_intn, each out N_SRC, carrying the per-source returns.
REQ-009 SHALL have ports mcu_sclk, mcu_csn and mcu_mosi, each out 1, feeding the core SPI slave.
REQ-010 SHALL have ports mcu_miso and mcu_intn, each in 1, driven from the core.
REQ-011 SHALL have port sel out SEL_W (max(1,clog2(N_SRC))): active source index.
REQ-012 SHALL have port switched out 1: one-cycle pulse on every selection change.

Function
REQ-013 SHALL pass each src_csn through a 2-FF synchronizer reset to 1; all decisions use synced csn.
REQ-014 SHALL keep a per-source claim counter: increment while synced csn low, saturate at CLAIM_CYCLES, clear when high.
REQ-015 SHALL implement FSM states IDLE, BUSY and GUARD; reset state is IDLE with sel=DEFAULT_SRC.
REQ-016 SHALL, in IDLE, go to BUSY when synced csn[sel]=0; that condition takes priority over claims in the same cycle.
REQ-017 SHALL, in IDLE otherwise, take the lowest-index source other than sel whose counter equals CLAIM_CYCLES as pending and go to GUARD.
REQ-018 SHALL, in BUSY, go to IDLE when synced csn[sel]=1; claims are never acted on in BUSY, and a claim still saturated on return to IDLE is taken next cycle.
REQ-019 SHALL, in GUARD, hold for exactly GUARD_CYCLES cycles (minimum 1), then set sel=pending, pulse switched for 1 cycle and go to IDLE; claims raised during GUARD are ignored and the counters keep running.
REQ-020 SHALL, when REVERT_CYCLES>0 and sel!=DEFAULT_SRC, count IDLE cycles with synced csn[sel]=1 and reset the count on leaving IDLE; at REVERT_CYCLES it SHALL take pending=DEFAULT_SRC and go to GUARD, with a simultaneous claim winning over revert.
REQ-021 SHALL drive mcu_sclk=src_sclk[sel], mcu_mosi=src_mosi[sel] and mcu_csn=src_csn[sel] combinationally from raw inputs and registered sel; mcu_csn SHALL be 1 in GUARD.
REQ-022 SHALL drive src_miso[sel]=mcu_miso and src_intn[sel]=mcu_intn, with every unselected src_miso and src_intn bit at 1.
REQ-023 SHALL, when N_SRC=1, never leave sel=0 and never pulse switched.

Reset
REQ-024 SHALL, while por_n=0 (asynchronous), hold sel=DEFAULT_SRC, FSM=IDLE, switched=0, counters=0 and synchronizers=1.
REQ-025 SHALL, if reset asserts mid-GUARD or mid-BUSY, discard pending and return to DEFAULT_SRC with no switched pulse.
REQ-026 SHALL allow the first switch only after CLAIM_CYCLES+2 cycles following reset release.

Structure
REQ-027 SHALL place the FSM state enum and the SEL_W function in the shared package mcu_spi_pkg.
REQ-028 SHALL use one sub-module, mcu_spi_sync, as the reset-to-1 2-FF synchronizer, instantiated per source.

Verification
REQ-029 SHALL cover: N_SRC=2, defaults, src_csn[1] low for 6 cycles with sel idle -> GUARD for 2 cycles with mcu_csn=1, then sel=1 and switched pulsed once.
REQ-030 SHALL cover: src_csn[1] low for only 3 cycles -> no switch, sel stays 0.
REQ-031 SHALL cover: source 0 transfers 8 bytes while src_csn[1] is held low -> no switch until csn[0] rises, then switch to 1; mcu_miso appears only on src_miso[0] before the switch.
REQ-032 SHALL cover: N_SRC=4, sources 2 and 3 claiming in the same cycle -> sel=2.
REQ-033 SHALL cover: REVERT_CYCLES=100, sel=1 idle for 100 cycles -> revert to sel=0 with a switched pulse; with REVERT_CYCLES=0 the bench holds 1000 idle cycles and sel stays 1.
REQ-034 SHALL cover: por_n pulsed low during GUARD -> sel=0, switched never pulsed, src_miso and src_intn of unselected sources =1.
